// File: rtl/fdiv_seq.sv
// fdiv_seq: sequential IEEE-754 single-precision divider, y = x1 / x2.
// The mantissa quotient comes from a restoring radix-2 divider that retires
// BITS_PER_CYCLE (1 or 2) bits per clock over N = 26 / BITS_PER_CYCLE cycles.
// Special operands skip the divide loop and finish one cycle after start.
// Denormal inputs are read as zero and denormal results are flushed to zero.
//
// Ports:
//   clk      rising-edge clock
//   rstn     asynchronous active-low reset
//   en       start request, sampled only in IDLE
//   x1, x2   dividend / divisor, IEEE single
//   flagin   writeback tag flag, captured with the operands
//   addin    writeback tag address, captured with the operands
//   y        quotient, updated with done, held until the next done
//   flagout  captured tag flag, updated with y
//   addout   captured tag address, updated with y
//   busy     high while in DIV or FIN
//   done     one-cycle result-valid pulse
//   exc      {invalid, divzero, overflow, underflow}, present only when
//            the macro FDIV_EXC_EN is defined
//
// state | meaning
// IDLE  | waiting for en; operands and tags are latched on start
// DIV   | restoring divide loop, counter counts N cycles down
// FIN   | round/pack the result, register outputs, pulse done
module fdiv_seq #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic        flagin,
  input  logic [4:0]  addin,
  output logic [31:0] y,
  output logic        flagout,
  output logic [4:0]  addout,
  output logic        busy,
  output logic        done
`ifdef FDIV_EXC_EN
  ,output logic [3:0] exc
`endif
);

  localparam int N = 26 / BITS_PER_CYCLE;
  localparam logic [4:0] N_CNT = 5'(N);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIN} state_t;

  state_t             state;
  logic [4:0]         cnt;
  logic               sign_r;
  logic signed [9:0]  exp_r;
  logic [23:0]        m2_r;
  logic [25:0]        rem_r;
  logic [25:0]        q_r;
  logic               spec_r;
  logic [31:0]        spec_y_r;
  logic               flag_r;
  logic [4:0]         add_r;

  // operand classification
  logic        sign_in;
  logic        nan1, nan2, inf1, inf2, zero1, zero2;
  logic        spec_in;
  logic [31:0] spec_y_in;
  logic [3:0]  spec_exc_in;
  logic signed [9:0] exp_in;

  assign sign_in = x1[31] ^ x2[31];
  assign nan1  = (&x1[30:23]) & (|x1[22:0]);
  assign nan2  = (&x2[30:23]) & (|x2[22:0]);
  assign inf1  = (&x1[30:23]) & ~(|x1[22:0]);
  assign inf2  = (&x2[30:23]) & ~(|x2[22:0]);
  assign zero1 = (x1[30:23] == 8'd0);
  assign zero2 = (x2[30:23] == 8'd0);
  assign exp_in = $signed({2'b00, x1[30:23]} - {2'b00, x2[30:23]} + 10'd127);

  always_comb begin
    spec_in     = 1'b1;
    spec_y_in   = 32'd0;
    spec_exc_in = 4'b0000;
    if (nan1 | nan2 | (zero1 & zero2) | (inf1 & inf2)) begin
      spec_y_in   = 32'h7FC0_0000;
      spec_exc_in = 4'b1000;
    end else if (inf1) begin
      spec_y_in = {sign_in, 8'hFF, 23'd0};
    end else if (inf2) begin
      spec_y_in = {sign_in, 31'd0};
    end else if (zero2) begin
      spec_y_in   = {sign_in, 8'hFF, 23'd0};
      spec_exc_in = 4'b0100;
    end else if (zero1) begin
      spec_y_in = {sign_in, 31'd0};
    end else begin
      spec_in = 1'b0;
    end
  end

  // One DIV cycle: BITS_PER_CYCLE restoring steps. The remainder is kept
  // pre-shifted for the next step; that never changes whether it is zero.
  logic [25:0] rem_n;
  logic [25:0] q_n;

  always_comb begin
    rem_n = rem_r;
    q_n   = q_r;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (rem_n >= {2'b00, m2_r}) begin
        rem_n = rem_n - {2'b00, m2_r};
        q_n   = {q_n[24:0], 1'b1};
      end else begin
        q_n   = {q_n[24:0], 1'b0};
      end
      rem_n = rem_n << 1;
    end
  end

  // Normalize, round to nearest even, range check.
  logic [23:0]       mant;
  logic              guard, sticky, inc;
  logic signed [9:0] exp_n, exp_f;
  logic [24:0]       mant_sum;
  logic [22:0]       frac_f;
  logic [31:0]       norm_y;
  logic              ovf, unf;

  always_comb begin
    if (q_r[25]) begin
      mant   = q_r[25:2];
      guard  = q_r[1];
      sticky = q_r[0] | (rem_r != 26'd0);
      exp_n  = exp_r;
    end else begin
      mant   = q_r[24:1];
      guard  = q_r[0];
      sticky = (rem_r != 26'd0);
      exp_n  = exp_r - 10'sd1;
    end
    inc      = guard & (sticky | mant[0]);
    mant_sum = {1'b0, mant} + {24'd0, inc};
    if (mant_sum[24]) begin
      frac_f = 23'd0;
      exp_f  = exp_n + 10'sd1;
    end else begin
      frac_f = mant_sum[22:0];
      exp_f  = exp_n;
    end
    ovf = 1'b0;
    unf = 1'b0;
    if (exp_f >= 10'sd255) begin
      norm_y = {sign_r, 8'hFF, 23'd0};
      ovf    = 1'b1;
    end else if (exp_f <= 10'sd0) begin
      norm_y = {sign_r, 31'd0};
      unf    = 1'b1;
    end else begin
      norm_y = {sign_r, exp_f[7:0], frac_f};
    end
  end

`ifdef FDIV_EXC_EN
  logic [3:0] spec_exc_r;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      cnt      <= 5'd0;
      sign_r   <= 1'b0;
      exp_r    <= 10'sd0;
      m2_r     <= 24'd0;
      rem_r    <= 26'd0;
      q_r      <= 26'd0;
      spec_r   <= 1'b0;
      spec_y_r <= 32'd0;
      flag_r   <= 1'b0;
      add_r    <= 5'd0;
      y        <= 32'd0;
      flagout  <= 1'b0;
      addout   <= 5'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef FDIV_EXC_EN
      spec_exc_r <= 4'd0;
      exc        <= 4'd0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (en) begin
            sign_r   <= sign_in;
            exp_r    <= exp_in;
            rem_r    <= {3'b001, x1[22:0]};
            m2_r     <= {1'b1, x2[22:0]};
            q_r      <= 26'd0;
            cnt      <= N_CNT;
            spec_r   <= spec_in;
            spec_y_r <= spec_y_in;
            flag_r   <= flagin;
            add_r    <= addin;
            busy     <= 1'b1;
            state    <= spec_in ? S_FIN : S_DIV;
`ifdef FDIV_EXC_EN
            spec_exc_r <= spec_exc_in;
`endif
          end
        end
        S_DIV: begin
          rem_r <= rem_n;
          q_r   <= q_n;
          cnt   <= cnt - 5'd1;
          if (cnt == 5'd1) state <= S_FIN;
        end
        S_FIN: begin
          y       <= spec_r ? spec_y_r : norm_y;
          flagout <= flag_r;
          addout  <= add_r;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= S_IDLE;
`ifdef FDIV_EXC_EN
          exc <= spec_r ? spec_exc_r : {2'b00, ovf, unf};
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef FDIV_EXC_EN
  // The exception bits only drive the optional exc port.
  logic unused_exc;
  assign unused_exc = ^{spec_exc_in, ovf, unf};
`endif

endmodule

// File: tb/tb_fdiv_seq.sv
module tb_fdiv_seq;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en1, en2;
  logic [31:0] x1, x2;
  logic        flagin;
  logic [4:0]  addin;
  logic [31:0] y1, y2;
  logic        flagout1, flagout2;
  logic [4:0]  addout1, addout2;
  logic        busy1, busy2, done1, done2;
`ifdef FDIV_EXC_EN
  logic [3:0]  exc1, exc2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fdiv_seq #(.BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rstn(rstn), .en(en1), .x1(x1), .x2(x2),
    .flagin(flagin), .addin(addin), .y(y1), .flagout(flagout1),
    .addout(addout1), .busy(busy1), .done(done1)
`ifdef FDIV_EXC_EN
    , .exc(exc1)
`endif
  );

  fdiv_seq #(.BITS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rstn(rstn), .en(en2), .x1(x1), .x2(x2),
    .flagin(flagin), .addin(addin), .y(y2), .flagout(flagout2),
    .addout(addout2), .busy(busy2), .done(done2)
`ifdef FDIV_EXC_EN
    , .exc(exc2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive operands at the negedge, pulse en through one rising edge (T0).
  // Returns 1 ns after T0.
  task automatic start_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                          input logic f, input logic [4:0] ad);
    @(negedge clk);
    x1 = a; x2 = b; flagin = f; addin = ad;
    if (sel == 1) en1 = 1'b1; else en2 = 1'b1;
    @(posedge clk); #1;
    en1 = 1'b0; en2 = 1'b0;
  endtask

  // Count rising edges after T0 until done is seen; -1 on timeout.
  task automatic wait_done(input int sel, output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if ((sel == 1 && done1) || (sel == 2 && done2)) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int bad;
    int gap;
    rstn = 1'b0; en1 = 1'b0; en2 = 1'b0;
    x1 = 32'd0; x2 = 32'd0; flagin = 1'b0; addin = 5'd0;
    #12;
    check("reset_y", y1, 32'd0);
    check("reset_tags", {26'd0, flagout1, addout1}, 32'd0);
    check("reset_busy_done", {30'd0, busy1, done1}, 32'd0);
    check("reset_y_bpc2", y2, 32'd0);
    @(negedge clk); rstn = 1'b1;

    // 6 / 2 with tags, busy window and latency at BPC=1
    start_op(1, 32'h40C0_0000, 32'h4000_0000, 1'b1, 5'd17);
    check("busy_after_start", {31'd0, busy1}, 32'd1);
    bad = 0; lat = -1;
    for (int k = 1; k <= 27; k++) begin
      @(posedge clk); #1;
      if (k <= 26 && !(busy1 && !done1)) bad++;
      if (k == 27 && done1) lat = 27;
    end
    check("busy_window", 32'(bad), 32'd0);
    check("lat_6div2", 32'(lat), 32'd27);
    check("y_6div2", y1, 32'h4040_0000);
    check("tag_6div2", {26'd0, flagout1, addout1}, {26'd0, 1'b1, 5'd17});
    check("busy_drop", {31'd0, busy1}, 32'd0);
`ifdef FDIV_EXC_EN
    check("exc_6div2", {28'd0, exc1}, 32'd0);
`endif
    @(posedge clk); #1;
    check("done_one_cycle", {31'd0, done1}, 32'd0);
    check("y_held", y1, 32'h4040_0000);

    // 1/3, sticky round-up, both widths
    start_op(1, 32'h3F80_0000, 32'h4040_0000, 1'b0, 5'd3);
    wait_done(1, lat);
    check("lat_1div3", 32'(lat), 32'd27);
    check("y_1div3", y1, 32'h3EAA_AAAB);
    start_op(2, 32'h3F80_0000, 32'h4040_0000, 1'b1, 5'd30);
    wait_done(2, lat);
    check("lat_1div3_bpc2", 32'(lat), 32'd14);
    check("y_1div3_bpc2", y2, 32'h3EAA_AAAB);
    check("tag_bpc2", {26'd0, flagout2, addout2}, {26'd0, 1'b1, 5'd30});

    // specials
    start_op(1, 32'h3F80_0000, 32'h0000_0000, 1'b0, 5'd9);
    wait_done(1, lat);
    check("lat_div0", 32'(lat), 32'd1);
    check("y_div0", y1, 32'h7F80_0000);
    check("tag_div0", {26'd0, flagout1, addout1}, {26'd0, 1'b0, 5'd9});
`ifdef FDIV_EXC_EN
    check("exc_div0", {28'd0, exc1}, 32'h4);
`endif
    start_op(1, 32'h0000_0000, 32'h0000_0000, 1'b0, 5'd0);
    wait_done(1, lat);
    check("lat_0div0", 32'(lat), 32'd1);
    check("y_0div0", y1, 32'h7FC0_0000);
`ifdef FDIV_EXC_EN
    check("exc_0div0", {28'd0, exc1}, 32'h8);
`endif
    start_op(1, 32'hFF80_0000, 32'h4000_0000, 1'b0, 5'd0);
    wait_done(1, lat);
    check("y_ninf_div2", y1, 32'hFF80_0000);
    start_op(1, 32'h4000_0000, 32'hFF80_0000, 1'b0, 5'd0);
    wait_done(1, lat);
    check("y_2div_ninf", y1, 32'h8000_0000);

    // range and sign
    start_op(1, 32'h7F7F_FFFF, 32'h0080_0000, 1'b0, 5'd0);
    wait_done(1, lat);
    check("lat_ovf", 32'(lat), 32'd27);
    check("y_ovf", y1, 32'h7F80_0000);
`ifdef FDIV_EXC_EN
    check("exc_ovf", {28'd0, exc1}, 32'h2);
`endif
    start_op(1, 32'h0080_0000, 32'h7F7F_FFFF, 1'b0, 5'd0);
    wait_done(1, lat);
    check("y_unf", y1, 32'h0000_0000);
`ifdef FDIV_EXC_EN
    check("exc_unf", {28'd0, exc1}, 32'h1);
`endif
    start_op(1, 32'hBF80_0000, 32'h3F80_0000, 1'b0, 5'd0);
    wait_done(1, lat);
    check("y_sign", y1, 32'hBF80_0000);

    // en pulsed while busy with different operands is ignored
    start_op(1, 32'h40C0_0000, 32'h4000_0000, 1'b1, 5'd5);
    repeat (4) @(posedge clk);
    @(negedge clk);
    x1 = 32'h3F80_0000; x2 = 32'h4040_0000; flagin = 1'b0; addin = 5'd22; en1 = 1'b1;
    @(posedge clk); #1; en1 = 1'b0;
    lat = -1;
    for (int k = 6; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done1) begin lat = k; break; end
    end
    check("lat_ignore", 32'(lat), 32'd27);
    check("y_ignore", y1, 32'h4040_0000);
    check("tag_ignore", {26'd0, flagout1, addout1}, {26'd0, 1'b1, 5'd5});
    bad = 0;
    repeat (30) begin @(posedge clk); #1; if (done1 || busy1) bad++; end
    check("no_extra_op", 32'(bad), 32'd0);

    // en held high across done: second op starts in the done cycle
    @(negedge clk);
    x1 = 32'h40C0_0000; x2 = 32'h4000_0000; flagin = 1'b0; addin = 5'd1; en1 = 1'b1;
    @(posedge clk); #1;
    wait_done(1, lat);
    check("lat_b2b_first", 32'(lat), 32'd27);
    check("y_b2b_first", y1, 32'h4040_0000);
    x1 = 32'hBF80_0000; x2 = 32'h3F80_0000; flagin = 1'b1; addin = 5'd2;
    gap = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 1) en1 = 1'b0;
      if (done1) begin gap = k; break; end
    end
    check("gap_b2b", 32'(gap), 32'd28);
    check("y_b2b_second", y1, 32'hBF80_0000);
    check("tag_b2b_second", {26'd0, flagout1, addout1}, {26'd0, 1'b1, 5'd2});

    // reset mid-operation
    start_op(1, 32'h3F80_0000, 32'h4040_0000, 1'b1, 5'd7);
    repeat (10) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check("midrst_y", y1, 32'd0);
    check("midrst_busy_done", {30'd0, busy1, done1}, 32'd0);
    @(negedge clk); @(negedge clk); rstn = 1'b1;
    bad = 0;
    repeat (30) begin @(posedge clk); #1; if (done1 || busy1) bad++; end
    check("midrst_no_done", 32'(bad), 32'd0);
    start_op(1, 32'h3F80_0000, 32'h4040_0000, 1'b1, 5'd7);
    wait_done(1, lat);
    check("lat_after_rst", 32'(lat), 32'd27);
    check("y_after_rst", y1, 32'h3EAA_AAAB);
    check("tag_after_rst", {26'd0, flagout1, addout1}, {26'd0, 1'b1, 5'd7});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
